// File: rtl/uart_word_xcvr.sv
// Full-duplex UART moving BYTES_PER_WORD-byte words MSB-byte first, with receive FIFO.
// Optional even parity bit on every byte when UART_XCVR_PARITY_EN is defined.
module uart_word_xcvr #(
  parameter int BYTES_PER_WORD = 4,
  parameter int OVERSAMPLE     = 16,
  parameter int RX_FIFO_DEPTH  = 4,
  localparam int W             = 8 * BYTES_PER_WORD
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  baud_div,
  input  logic [W-1:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  output logic         tx_busy,
  output logic         txd,
  input  logic         rxd,
  output logic [W-1:0] rx_data,
  output logic         rx_err,
  output logic         rx_valid,
  input  logic         rx_ready,
  output logic         rx_overrun
);

  localparam int OW = $clog2(OVERSAMPLE);
  localparam int BW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int AW = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
  localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_MID    = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_XCVR_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

`ifdef UART_XCVR_PARITY_EN
  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(RX_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // tick generator
  logic [15:0] tick_cnt;
  logic        tick;

  assign tick = (tick_cnt == baud_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= '0;
    else        tick_cnt <= tick ? 16'd0 : tick_cnt + 16'd1;
  end

  // transmitter
  state_t         tx_state;
  logic [OW-1:0]  tx_os;
  logic [2:0]     tx_bit;
  logic [BW-1:0]  tx_byte;
  logic [W-1:0]   tx_buf;
  logic [7:0]     tx_cur;
  logic           tx_val;

  assign tx_cur = tx_buf[W-1 -: 8];

  always_comb begin
    tx_val = 1'b1;
    case (tx_state)
      S_START:  tx_val = 1'b0;
      S_DATA:   tx_val = tx_cur[tx_bit];
`ifdef UART_XCVR_PARITY_EN
      S_PARITY: tx_val = even_par(tx_cur);
`endif
      default:  tx_val = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      tx_os    <= '0;
      tx_bit   <= '0;
      tx_byte  <= '0;
      tx_buf   <= '0;
      txd      <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
    end else if (tx_state == S_IDLE) begin
      if (tx_valid && tx_ready) begin
        tx_buf   <= tx_data;
        tx_state <= S_START;
        tx_os    <= '0;
        tx_byte  <= '0;
        tx_ready <= 1'b0;
        tx_busy  <= 1'b1;
      end
    end else if (tick) begin
      // the line only moves on the first tick of a bit period
      if (tx_os == '0) txd <= tx_val;
      if (tx_os != OS_LAST) begin
        tx_os <= tx_os + 1'b1;
      end else begin
        tx_os <= '0;
        case (tx_state)
          S_START: begin
            tx_state <= S_DATA;
            tx_bit   <= '0;
          end
          S_DATA: begin
            if (tx_bit == 3'd7) begin
`ifdef UART_XCVR_PARITY_EN
              tx_state <= S_PARITY;
`else
              tx_state <= S_STOP;
`endif
            end
            tx_bit <= tx_bit + 1'b1;
          end
`ifdef UART_XCVR_PARITY_EN
          S_PARITY: tx_state <= S_STOP;
`endif
          default: begin
            tx_buf <= tx_buf << 8;
            if (tx_byte == BYTE_LAST) begin
              tx_state <= S_IDLE;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
            end else begin
              tx_byte  <= tx_byte + 1'b1;
              tx_state <= S_START;
            end
          end
        endcase
      end
    end
  end

  // receiver: two synchroniser flops plus one history flop for edge detection
  logic rxd_p0, rxd_p1, rxd_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
      rxd_p2 <= 1'b1;
    end else begin
      rxd_p0 <= rxd;
      rxd_p1 <= rxd_p0;
      rxd_p2 <= rxd_p1;
    end
  end

  state_t         rx_state;
  logic [OW-1:0]  rx_os;
  logic [2:0]     rx_bit;
  logic [BW-1:0]  rx_byte;
  logic [7:0]     rx_sh;
  logic [W-1:0]   rx_word;
  logic           rx_werr;
  logic [W-1:0]   push_word;
  logic           push_err;
  logic           rx_push;

  assign push_word = W'({rx_word, rx_sh});
  assign push_err  = rx_werr | ~rxd_p1;
  assign rx_push   = tick && (rx_state == S_STOP) && (rx_os == OS_LAST) && (rx_byte == BYTE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= S_IDLE;
      rx_os    <= '0;
      rx_bit   <= '0;
      rx_byte  <= '0;
      rx_sh    <= '0;
      rx_word  <= '0;
      rx_werr  <= 1'b0;
    end else if (rx_state == S_IDLE) begin
      if (rxd_p2 && !rxd_p1) begin
        rx_state <= S_START;
        rx_os    <= '0;
      end
    end else if (tick) begin
      if (rx_state == S_START) begin
        // a start bit that is high at mid-bit was only a glitch
        if (rx_os == OS_MID) begin
          rx_os    <= '0;
          rx_bit   <= '0;
          rx_state <= rxd_p1 ? S_IDLE : S_DATA;
        end else begin
          rx_os <= rx_os + 1'b1;
        end
      end else if (rx_os != OS_LAST) begin
        rx_os <= rx_os + 1'b1;
      end else begin
        rx_os <= '0;
        case (rx_state)
          S_DATA: begin
            rx_sh <= {rxd_p1, rx_sh[7:1]};
            if (rx_bit == 3'd7) begin
`ifdef UART_XCVR_PARITY_EN
              rx_state <= S_PARITY;
`else
              rx_state <= S_STOP;
`endif
            end
            rx_bit <= rx_bit + 1'b1;
          end
`ifdef UART_XCVR_PARITY_EN
          S_PARITY: begin
            if (rxd_p1 != even_par(rx_sh)) rx_werr <= 1'b1;
            rx_state <= S_STOP;
          end
`endif
          default: begin
            rx_state <= S_IDLE;
            if (rx_byte == BYTE_LAST) begin
              rx_byte <= '0;
              rx_word <= '0;
              rx_werr <= 1'b0;
            end else begin
              rx_byte <= rx_byte + 1'b1;
              rx_word <= push_word;
              rx_werr <= push_err;
            end
          end
        endcase
      end
    end
  end

  // receive FIFO with a registered show-ahead head
  logic [W-1:0]  fifo_mem [RX_FIFO_DEPTH];
  logic          fifo_err [RX_FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   fifo_cnt, cnt_d;
  logic          pop, full, wr_en;
  logic [W-1:0]  head_d;
  logic          herr_d;

  assign pop   = rx_valid && rx_ready;
  assign full  = (fifo_cnt == (AW+1)'(RX_FIFO_DEPTH));
  assign wr_en = rx_push && (!full || pop);

  always_comb begin
    head_d = rx_data;
    herr_d = rx_err;
    cnt_d  = fifo_cnt;
    case ({wr_en, pop})
      2'b10:   cnt_d = fifo_cnt + 1'b1;
      2'b01:   cnt_d = fifo_cnt - 1'b1;
      default: cnt_d = fifo_cnt;
    endcase
    if (pop) begin
      if (fifo_cnt > (AW+1)'(1)) begin
        head_d = fifo_mem[ptr_inc(rd_ptr)];
        herr_d = fifo_err[ptr_inc(rd_ptr)];
      end else if (rx_push) begin
        head_d = push_word;
        herr_d = push_err;
      end
    end else if (fifo_cnt == '0 && rx_push) begin
      head_d = push_word;
      herr_d = push_err;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_mem[wr_ptr] <= push_word;
      fifo_err[wr_ptr] <= push_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_cnt   <= '0;
      rx_data    <= '0;
      rx_err     <= 1'b0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)   rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt   <= cnt_d;
      rx_data    <= head_d;
      rx_err     <= herr_d;
      rx_valid   <= (cnt_d != '0);
      rx_overrun <= rx_push && full && !pop;
    end
  end

endmodule

// File: tb/tb_uart_word_xcvr.sv
// Directed self-checking bench for uart_word_xcvr at baud_div=0, OVERSAMPLE=16, depth 4.
module tb_uart_word_xcvr;
  localparam int BPW = 4;
  localparam int OS  = 16;
  localparam int W   = 32;
`ifdef UART_XCVR_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int TOT = OS * FB * BPW;
  localparam int RXV = TOT - 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  baud_div = 16'd0;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready, tx_busy, txd;
  logic [W-1:0] rx_data;
  logic         rx_err, rx_valid, rx_overrun;
  logic         rx_ready = 1'b0;
  logic         loop = 1'b0;
  logic         rxd_drv = 1'b1;
  wire          rxd = loop ? txd : rxd_drv;

  int checks = 0;
  int failures = 0;
  int ovr_cnt = 0;

  uart_word_xcvr #(.BYTES_PER_WORD(BPW), .OVERSAMPLE(OS), .RX_FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy), .txd(txd),
    .rxd(rxd), .rx_data(rx_data), .rx_err(rx_err), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_overrun === 1'b1) ovr_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // serial frame, first bit on the line in bit 0; bit 10 pads to 1 without parity
  function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef UART_XCVR_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, 1'b1, b, 1'b0};
`endif
  endfunction

  task automatic drive_bit(input logic b);
    rxd_drv = b;
    repeat (OS) @(negedge clk);
  endtask

  // drives one word on rxd with an idle bit after every byte; call at a negedge
  task automatic drive_word(input logic [W-1:0] w, input int bad_stop_byte, input bit pop_at_push);
    logic [10:0] f;
    for (int j = 0; j < BPW; j++) begin
      f = frame_of(w[W-1-8*j -: 8]);
      for (int i = 0; i < FB - 1; i++) drive_bit(f[i]);
      rxd_drv = (j == bad_stop_byte) ? 1'b0 : 1'b1;
      if (pop_at_push && j == BPW - 1) begin
        repeat (10) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (OS - 11) @(negedge clk);
      end else begin
        repeat (OS) @(negedge clk);
      end
      drive_bit(1'b1);
    end
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_rx(input string tag);
    int n = 0;
    while (rx_valid !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, rx_valid, 1'b1);
  endtask

  task automatic send_tx(input logic [W-1:0] w);
    @(negedge clk);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] wv;
    logic [10:0]  obs;
    logic [W-1:0] q [5];

    // reset values
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 32'h0);
    check("rst_rx_err", rx_err, 1'b0);
    check("rst_rx_overrun", rx_overrun, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // transmit waveform
    wv = 32'hA5C30F81;
    @(negedge clk);
    tx_data  = wv;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    check("tx_busy_after_accept", tx_busy, 1'b1);
    check("tx_ready_after_accept", tx_ready, 1'b0);
    check("txd_idle_accept_cycle", txd, 1'b1);
    @(posedge clk);
    #1;
    check("txd_start_first_tick", txd, 1'b0);
    for (int j = 0; j < BPW; j++) begin
      obs = '1;
      for (int i = 0; i < FB; i++) begin
        repeat ((j == 0 && i == 0) ? 8 : 16) @(posedge clk);
        #1;
        obs[i] = txd;
      end
      check($sformatf("tx_frame_byte%0d", j), obs, frame_of(wv[W-1-8*j -: 8]));
    end
    repeat (6) @(posedge clk);
    #1;
    check("tx_ready_low_last_cycle", tx_ready, 1'b0);
    check("tx_busy_high_last_cycle", tx_busy, 1'b1);
    @(posedge clk);
    #1;
    check("tx_ready_returns", tx_ready, 1'b1);
    check("tx_busy_falls", tx_busy, 1'b0);
    check("txd_idle_after", txd, 1'b1);

    // loopback word with exact rx_valid timing
    repeat (4) @(posedge clk);
    loop = 1'b1;
    @(negedge clk);
    tx_data  = 32'h12345678;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (RXV - 1) @(posedge clk);
    #1;
    check("loop_rx_valid_early", rx_valid, 1'b0);
    @(posedge clk);
    #1;
    check("loop_rx_valid", rx_valid, 1'b1);
    check("loop_rx_data", rx_data, 32'h12345678);
    check("loop_rx_err", rx_err, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    pop_one();
    check("loop_after_pop", rx_valid, 1'b0);
    loop = 1'b0;

    // glitch on idle line
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (3) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_word", rx_valid, 1'b0);
    drive_word(32'hDEADBEEF, -1, 1'b0);
    wait_rx("glitch_word_valid");
    check("glitch_word_data", rx_data, 32'hDEADBEEF);
    check("glitch_word_err", rx_err, 1'b0);
    pop_one();

    // framing error on the second byte's stop bit
    drive_word(32'hCAFEF00D, 1, 1'b0);
    drive_word(32'h0BADF00D, -1, 1'b0);
    check("ferr_valid", rx_valid, 1'b1);
    check("ferr_data", rx_data, 32'hCAFEF00D);
    check("ferr_err", rx_err, 1'b1);
    pop_one();
    check("ferr_next_data", rx_data, 32'h0BADF00D);
    check("ferr_next_err", rx_err, 1'b0);
    pop_one();
    check("ferr_empty", rx_valid, 1'b0);

    // overrun with a full FIFO
    check("ovr_none_yet", ovr_cnt, 0);
    q[0] = 32'h01020304; q[1] = 32'h10203040; q[2] = 32'hA1B2C3D4;
    q[3] = 32'h55AA33CC; q[4] = 32'hFEDCBA98;
    for (int k = 0; k < 5; k++) drive_word(q[k], -1, 1'b0);
    check("ovr_pulse_once", ovr_cnt, 1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ovr_fifo_word%0d", k), rx_data, q[k]);
      pop_one();
    end
    check("ovr_fifo_empty", rx_valid, 1'b0);

    // push and pop in the same cycle while full
    q[0] = 32'h11112222; q[1] = 32'h33334444; q[2] = 32'h55556666;
    q[3] = 32'h77778888; q[4] = 32'h9999AAAA;
    for (int k = 0; k < 4; k++) drive_word(q[k], -1, 1'b0);
    drive_word(q[4], -1, 1'b1);
    check("pushpop_no_overrun", ovr_cnt, 1);
    for (int k = 1; k < 4; k++) begin
      check($sformatf("pushpop_word%0d", k), rx_data, q[k]);
      pop_one();
    end
    check("pushpop_last_word", rx_data, q[4]);
    check("pushpop_still_valid", rx_valid, 1'b1);

    // reset in the middle of the second byte
    loop = 1'b1;
    send_tx(32'h0F1E2D3C);
    repeat (OS * FB + 48) @(negedge clk);
    check("midrst_busy_before", tx_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_txd", txd, 1'b1);
    check("midrst_rx_valid", rx_valid, 1'b0);
    check("midrst_tx_ready", tx_ready, 1'b1);
    check("midrst_tx_busy", tx_busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("postrst_no_partial", rx_valid, 1'b0);
    send_tx(32'h89ABCDEF);
    wait_rx("postrst_valid");
    check("postrst_data", rx_data, 32'h89ABCDEF);
    check("postrst_err", rx_err, 1'b0);
    pop_one();
    check("postrst_empty", rx_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
